// File: rtl/clock_controller_pkg.sv
// rtl/clock_controller_pkg.sv - shared state encoding and divider defaults for clock_controller
// Contents:
//   state_t            controller state, encoded as it appears on the mode port
//   DIV_WIDTH_DEFAULT  default prescaler width
//   DIV_DEFAULT_VALUE  default divider reload value
package clock_controller_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_RUNNING = 2'b01,
    ST_STEP    = 2'b10,
    ST_HALTED  = 2'b11
  } state_t;

  localparam int          DIV_WIDTH_DEFAULT = 24;
  localparam logic [23:0] DIV_DEFAULT_VALUE = 24'd4_999_999;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divider register and free-run down-counter
// Ports:
//   clk        system clock
//   clr        synchronous active-high reset; div_reg and counter go to DIV_DEFAULT
//   start      controller is entering free-run this cycle; counter loads div_reg
//   run        controller is in free-run and stays there this cycle
//   div_load   writes div_value into div_reg (and into the counter while running)
//   div_value  new divider value
//   tick       combinational: counter expired this cycle, an enable is due
module tick_prescaler
  import clock_controller_pkg::*;
#(
  parameter int                   DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = '0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 run,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] count;

  // A divider write while counting restarts the period, so it never fires.
  assign tick = run && !div_load && (count == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      div_reg <= DIV_DEFAULT;
      count   <= DIV_DEFAULT;
    end else begin
      if (div_load) begin
        div_reg <= div_value;
      end
      // A write arriving on the entry cycle takes effect immediately too.
      if (div_load && (start || run)) begin
        count <= div_value;
      end else if (start) begin
        count <= div_reg;
      end else if (run) begin
        count <= (count == '0) ? div_reg : count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_controller.sv
// rtl/clock_controller.sv - CPU clock-enable controller: free-run, single-step and halt
// Ports:
//   clk          system clock
//   clr          synchronous active-high reset
//   step_pulse   one-cycle request for a single CPU tick
//   run_toggle   one-cycle pulse toggling free-run
//   restart      one-cycle pulse leaving HALTED (only while halt is low)
//   halt         level, HLT from the CPU control word
//   div_load     loads div_value into the divider register
//   div_value    new divider value
//   cpu_clk_en   registered one-cycle CPU clock enable
//   cpu_clk_led  registered, toggles on every enable
//   mode         current state (STOPPED=00 RUNNING=01 STEP=10 HALTED=11)
//   tick_count   number of enables issued, wrapping
module clock_controller
  import clock_controller_pkg::*;
#(
  parameter int                   DIV_WIDTH   = DIV_WIDTH_DEFAULT,
  parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT = DIV_DEFAULT_VALUE
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 step_pulse,
  input  logic                 run_toggle,
  input  logic                 restart,
  input  logic                 halt,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  output logic                 cpu_clk_en,
  output logic                 cpu_clk_led,
  output logic [1:0]           mode,
  output logic [15:0]          tick_count
);

  state_t state;
  state_t next_state;
  logic   start;
  logic   run;
  logic   step_fire;
  logic   tick;
  logic   fire;

  // Input priority: halt > restart > run_toggle > step_pulse (clr handled in the register).
  // restart outranks run_toggle everywhere, so outside HALTED it simply masks the cycle.
  always_comb begin
    next_state = state;
    if (halt) begin
      next_state = ST_HALTED;
    end else begin
      case (state)
        ST_STOPPED: begin
          if (restart)         next_state = ST_STOPPED;
          else if (run_toggle) next_state = ST_RUNNING;
          else if (step_pulse) next_state = ST_STEP;
        end
        ST_RUNNING: begin
          if (!restart && run_toggle) next_state = ST_STOPPED;
        end
        ST_STEP:    next_state = ST_STOPPED;
        ST_HALTED: begin
          if (restart) next_state = ST_STOPPED;
        end
        default:    next_state = ST_STOPPED;
      endcase
    end
  end

  assign start     = (state != ST_RUNNING) && (next_state == ST_RUNNING);
  assign run       = (state == ST_RUNNING) && (next_state == ST_RUNNING);
  // The step enable is registered on the entry edge, so it is visible during STEP.
  assign step_fire = (state == ST_STOPPED) && (next_state == ST_STEP);
  assign fire      = step_fire || tick;

  tick_prescaler #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_prescaler (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .run      (run),
    .div_load (div_load),
    .div_value(div_value),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_STOPPED;
      cpu_clk_en  <= 1'b0;
      cpu_clk_led <= 1'b0;
      tick_count  <= 16'd0;
    end else begin
      state      <= next_state;
      cpu_clk_en <= fire;
      if (fire) begin
        cpu_clk_led <= ~cpu_clk_led;
        tick_count  <= tick_count + 16'd1;
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_clock_controller.sv
// tb/tb_clock_controller.sv - scoreboard bench for clock_controller
module tb_clock_controller;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        step_pulse = 1'b0;
  logic        run_toggle = 1'b0;
  logic        restart = 1'b0;
  logic        halt = 1'b0;
  logic        div_load = 1'b0;
  logic [23:0] div_value = '0;
  logic        cpu_clk_en;
  logic        cpu_clk_led;
  logic [1:0]  mode;
  logic [15:0] tick_count;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          exp_q[$];
  bit          mon_on = 1'b1;
  logic        exp_led = 1'b0;
  logic [15:0] exp_tick = '0;

  clock_controller dut (
    .clk        (clk),
    .clr        (clr),
    .step_pulse (step_pulse),
    .run_toggle (run_toggle),
    .restart    (restart),
    .halt       (halt),
    .div_load   (div_load),
    .div_value  (div_value),
    .cpu_clk_en (cpu_clk_en),
    .cpu_clk_led(cpu_clk_led),
    .mode       (mode),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Each expected enable is the edge number after which cpu_clk_en must read 1.
  always @(negedge clk) begin : monitor
    int e;
    if (mon_on) begin
      if (cpu_clk_en) begin
        exp_led  = ~exp_led;
        exp_tick = exp_tick + 16'd1;
        if (exp_q.size() == 0) begin
          check("unexpected_en", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          check("en_cycle", cyc, e);
        end
        check("led_on_en", cpu_clk_led, exp_led);
        check("tick_on_en", tick_count, exp_tick);
      end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
        e = exp_q.pop_front();
        check("missed_en", cyc, -e);
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    step_pulse = 1'b0; run_toggle = 1'b0; restart = 1'b0; halt = 1'b0; div_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    exp_led  = 1'b0;
    exp_tick = '0;
    check("rst_en", cpu_clk_en, 0);
    check("rst_led", cpu_clk_led, 0);
    check("rst_mode", mode, 0);
    check("rst_tick", tick_count, 0);
  endtask

  task automatic load_div(input int v);
    @(negedge clk);
    div_load = 1'b1;
    div_value = v[23:0];
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic pulse_run(output int k);
    @(negedge clk);
    run_toggle = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    run_toggle = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk);
    step_pulse = 1'b1;
    exp_q.push_back(cyc + 1);
    @(negedge clk);
    step_pulse = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    int k;
    int s;

    // Free-run at divider 3: enable every 4 cycles, first one 4 edges after the toggle.
    do_reset();
    load_div(3);
    check("div_load_mode", mode, 0);
    pulse_run(k);
    for (int i = 1; i <= 5; i++) exp_q.push_back(k + 4 * i);
    check("run_mode", mode, 1);
    wait_cyc(k + 20);
    check("run_tick5", tick_count, 5);
    check("run_led", cpu_clk_led, 1);
    pulse_run(s);
    check("stop_mode", mode, 0);
    tick_n(10);
    check("run_pending", exp_q.size(), 0);

    // Divider rewritten mid-count: counter restarts at 1, no enable on the write cycle.
    pulse_run(k);
    exp_q.push_back(k + 4);
    exp_q.push_back(k + 8);
    exp_q.push_back(k + 10);
    wait_cyc(k + 5);
    div_load = 1'b1;
    div_value = 24'd1;
    @(negedge clk);
    div_load = 1'b0;
    wait_cyc(k + 10);
    pulse_run(s);
    tick_n(4);
    check("reload_pending", exp_q.size(), 0);
    check("reload_tick", tick_count, 8);

    // Single-step, then a two-cycle step pulse whose second half lands in STEP.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      tick_n(9);
    end
    check("step_tick3", tick_count, 3);
    check("step_mode", mode, 0);
    check("step_pending", exp_q.size(), 0);
    @(negedge clk);
    step_pulse = 1'b1;
    exp_q.push_back(cyc + 1);
    @(negedge clk);
    @(negedge clk);
    step_pulse = 1'b0;
    tick_n(5);
    check("step_ignored", tick_count, 4);

    // Halt while free-running at divider 0.
    do_reset();
    load_div(0);
    pulse_run(k);
    exp_q.push_back(k + 1);
    exp_q.push_back(k + 2);
    exp_q.push_back(k + 3);
    wait_cyc(k + 3);
    halt = 1'b1;
    @(negedge clk);
    check("halt_mode", mode, 3);
    tick_n(3);
    pulse_restart();
    check("halt_restart_held", mode, 3);
    halt = 1'b0;
    tick_n(2);
    check("halt_low_stay", mode, 3);
    pulse_restart();
    check("halt_restart", mode, 0);
    check("halt_tick", tick_count, 3);
    check("halt_pending", exp_q.size(), 0);

    // Simultaneous inputs.
    do_reset();
    @(negedge clk);
    run_toggle = 1'b1;
    step_pulse = 1'b1;
    @(negedge clk);
    run_toggle = 1'b0;
    step_pulse = 1'b0;
    check("run_beats_step", mode, 1);
    tick_n(3);
    check("no_step_en", tick_count, 0);
    @(negedge clk);
    halt = 1'b1;
    run_toggle = 1'b1;
    @(negedge clk);
    run_toggle = 1'b0;
    check("halt_beats_run", mode, 3);
    halt = 1'b0;
    pulse_restart();
    check("sim_restart", mode, 0);

    // Reset while running with the counter at 1, held across the edge where it would fire.
    do_reset();
    load_div(3);
    pulse_run(k);
    exp_q.push_back(k + 4);
    wait_cyc(k + 6);
    check("pre_clr_tick", tick_count, 1);
    check("pre_clr_led", cpu_clk_led, 1);
    clr = 1'b1;
    @(negedge clk);
    check("clr_en", cpu_clk_en, 0);
    check("clr_led", cpu_clk_led, 0);
    check("clr_mode", mode, 0);
    check("clr_tick", tick_count, 0);
    @(negedge clk);
    check("clr_en2", cpu_clk_en, 0);
    clr = 1'b0;
    exp_q.delete();
    exp_led  = 1'b0;
    exp_tick = '0;
    tick_n(6);
    check("post_clr_mode", mode, 0);

    // tick_count wrap at divider 0.
    do_reset();
    load_div(0);
    mon_on = 1'b0;
    pulse_run(k);
    wait_cyc(k + 65535);
    check("wrap_ffff", tick_count, 16'hFFFF);
    @(negedge clk);
    check("wrap_zero", tick_count, 0);
    check("wrap_en", cpu_clk_en, 1);
    halt = 1'b1;
    tick_n(2);
    check("wrap_halt_en", cpu_clk_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
